// File: rtl/vvp_acc_if.sv
// Beat and result handshake bundle for one vvp_acc lane.
// Master is the lane controller/consumer side; slave is the accumulator.
interface vvp_acc_if #(
    parameter int SW = 8,
    parameter int OW = 32
);
    logic                 in_vld;
    logic                 in_rdy;
    logic signed [SW-1:0] S;
    logic                 sh;
    logic                 neg;
    logic                 last;
    logic                 out_vld;
    logic                 out_rdy;
    logic signed [OW-1:0] out;
    logic                 out_ovf;

    modport master (
        output in_vld, S, sh, neg, last, out_rdy,
        input  in_rdy, out_vld, out, out_ovf
    );

    modport slave (
        input  in_vld, S, sh, neg, last, out_rdy,
        output in_rdy, out_vld, out, out_ovf
    );
endinterface

// File: rtl/vvp_acc.sv
// Bit-serial Horner accumulator: acc = (acc << sh) +/- S per accepted beat,
// emitting the finished dot product with a sticky overflow flag.
module vvp_acc #(
    parameter int N  = 64,
    parameter int SW = $clog2(N) + 2,
    parameter int OW = 32
) (
    input logic      clk,
    input logic      rst,
    vvp_acc_if.slave bus
);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    state_t               state, state_d;
    logic signed [OW-1:0] acc, acc_d;
    logic                 sticky, sticky_d;
    logic signed [OW-1:0] out_q, out_d;
    logic                 ovf_q, ovf_d;
    logic                 vld_q, vld_d;

    logic                 in_rdy;
    logic                 accept;
    logic        [OW-1:0] base;
    logic                 shift_ovf;
    logic signed [OW:0]   s_ext;
    logic signed [OW:0]   addend;
    logic        [OW+1:0] sum;
    logic                 add_ovf;
    logic                 ovf_beat;
    logic        [OW-1:0] nxt;

    assign in_rdy = !vld_q || bus.out_rdy;
    assign accept = bus.in_vld && in_rdy;

    // Datapath: S is widened to OW+1 so negating its most negative value is exact,
    // and the sum carries two guard bits so the add overflow test sees full precision.
    always_comb begin
        base      = '0;
        shift_ovf = 1'b0;
        if (state == ACC) begin
            if (bus.sh) begin
                base      = {acc[OW-2:0], 1'b0};
                shift_ovf = acc[OW-1] ^ acc[OW-2];
            end else begin
                base = acc;
            end
        end
        s_ext    = {{(OW + 1 - SW){bus.S[SW-1]}}, bus.S};
        addend   = bus.neg ? -s_ext : s_ext;
        sum      = {{2{base[OW-1]}}, base} + {addend[OW], addend};
        add_ovf  = (sum[OW+1] != sum[OW]) || (sum[OW] != sum[OW-1]);
        ovf_beat = shift_ovf || add_ovf;
        nxt      = sum[OW-1:0];
    end

    always_comb begin
        state_d  = state;
        acc_d    = acc;
        sticky_d = sticky;
        out_d    = out_q;
        ovf_d    = ovf_q;
        vld_d    = vld_q && !bus.out_rdy;
        if (accept) begin
            if (bus.last) begin
                out_d    = nxt;
                ovf_d    = sticky || ovf_beat;
                vld_d    = 1'b1;
                acc_d    = '0;
                sticky_d = 1'b0;
                state_d  = IDLE;
            end else begin
                acc_d    = nxt;
                sticky_d = sticky || ovf_beat;
                state_d  = ACC;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc    <= '0;
            sticky <= 1'b0;
            out_q  <= '0;
            ovf_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            state  <= state_d;
            acc    <= acc_d;
            sticky <= sticky_d;
            out_q  <= out_d;
            ovf_q  <= ovf_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.in_rdy  = in_rdy;
    assign bus.out_vld = vld_q;
    assign bus.out     = out_q;
    assign bus.out_ovf = ovf_q;

endmodule

// File: tb/tb_vvp_acc.sv
// Directed self-checking bench for vvp_acc (N=64 -> SW=8, OW=10).
module tb_vvp_acc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests  = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    vvp_acc_if #(.SW(8), .OW(10)) bus ();

    vvp_acc #(.N(64), .OW(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for in_rdy, let it be accepted on the next edge.
    task automatic send(input logic signed [7:0] s, input logic sh, input logic neg,
                        input logic last);
        int n = 0;
        bus.in_vld = 1'b1;
        bus.S      = s;
        bus.sh     = sh;
        bus.neg    = neg;
        bus.last   = last;
        while (!bus.in_rdy && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) chk("send_timeout", 32'(bus.in_rdy), 1);
        tick();
        bus.in_vld = 1'b0;
    endtask

    initial begin
        bus.in_vld  = 1'b0;
        bus.S       = '0;
        bus.sh      = 1'b0;
        bus.neg     = 1'b0;
        bus.last    = 1'b0;
        bus.out_rdy = 1'b1;
        repeat (3) tick();
        chk("rst_vld", 32'(bus.out_vld), 0);
        chk("rst_out", $signed(bus.out), 0);
        chk("rst_ovf", 32'(bus.out_ovf), 0);
        rst = 1'b0;
        tick();
        chk("idle_rdy", 32'(bus.in_rdy), 1);

        // single beat
        send(8'sd5, 1'b0, 1'b0, 1'b1);
        chk("single_vld", 32'(bus.out_vld), 1);
        chk("single_out", $signed(bus.out), 5);
        chk("single_ovf", 32'(bus.out_ovf), 0);
        tick();
        chk("single_drop", 32'(bus.out_vld), 0);

        // Horner: 3 -> 4 -> 9, first-beat sh ignored, idle gaps hold the partial sum
        send(8'sd3, 1'b1, 1'b0, 1'b0);
        tick();
        send(-8'sd2, 1'b1, 1'b0, 1'b0);
        chk("horner_mid_vld", 32'(bus.out_vld), 0);
        repeat (2) tick();
        send(8'sd1, 1'b1, 1'b0, 1'b1);
        chk("horner_vld", 32'(bus.out_vld), 1);
        chk("horner_out", $signed(bus.out), 9);

        // sign plane: -4 -> -5
        send(8'sd4, 1'b0, 1'b1, 1'b0);
        send(8'sd3, 1'b1, 1'b0, 1'b1);
        chk("sign_out", $signed(bus.out), -5);
        chk("sign_ovf", 32'(bus.out_ovf), 0);

        // most negative S negated
        send(-8'sd128, 1'b0, 1'b1, 1'b1);
        chk("negmin_out", $signed(bus.out), 128);
        chk("negmin_ovf", 32'(bus.out_ovf), 0);
        tick();

        // backpressure: result 7 held, pending beat must wait
        bus.out_rdy = 1'b0;
        send(8'sd7, 1'b0, 1'b0, 1'b1);
        chk("bp_vld", 32'(bus.out_vld), 1);
        chk("bp_rdy", 32'(bus.in_rdy), 0);
        bus.in_vld = 1'b1;
        bus.S      = 8'sd2;
        bus.sh     = 1'b0;
        bus.neg    = 1'b0;
        bus.last   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_out", $signed(bus.out), 7);
            chk("bp_hold_vld", 32'(bus.out_vld), 1);
        end
        bus.out_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", 32'(bus.in_rdy), 1);
        tick();
        chk("bp_reload_vld", 32'(bus.out_vld), 1);
        chk("bp_reload_out", $signed(bus.out), 2);
        bus.S = 8'sd11;
        tick();
        chk("b2b_out0", $signed(bus.out), 11);
        bus.S = 8'sd12;
        tick();
        chk("b2b_out1", $signed(bus.out), 12);
        chk("b2b_vld", 32'(bus.out_vld), 1);
        bus.in_vld = 1'b0;
        tick();
        chk("b2b_drop", 32'(bus.out_vld), 0);

        // overflow: 100 -> 200 -> 400 -> 800 wraps to -224 in 10 bits
        send(8'sd100, 1'b0, 1'b0, 1'b0);
        send(8'sd0, 1'b1, 1'b0, 1'b0);
        send(8'sd0, 1'b1, 1'b0, 1'b0);
        send(8'sd0, 1'b1, 1'b0, 1'b1);
        chk("ovf_out", $signed(bus.out), -224);
        chk("ovf_flag", 32'(bus.out_ovf), 1);
        send(8'sd1, 1'b0, 1'b0, 1'b1);
        chk("ovf_clear_out", $signed(bus.out), 1);
        chk("ovf_clear_flag", 32'(bus.out_ovf), 0);
        tick();

        // reset mid-accumulation discards the partial sum
        send(8'sd50, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        chk("midrst_vld", 32'(bus.out_vld), 0);
        chk("midrst_out", $signed(bus.out), 0);
        rst = 1'b0;
        tick();
        chk("postrst_vld", 32'(bus.out_vld), 0);
        chk("postrst_out", $signed(bus.out), 0);
        send(8'sd2, 1'b0, 1'b0, 1'b1);
        chk("postrst_result", $signed(bus.out), 2);
        chk("postrst_rvld", 32'(bus.out_vld), 1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vvp_acc.md
Name: vvp_acc

Overview:
- Bit-serial accumulator stage placed directly downstream of the vector-vector product tree.
- Consumes one signed partial sum S per accepted beat and folds it into a wide running accumulator using Horner form: acc = (acc << sh) ± S.
- Emits the finished dot product over a valid/ready output with a sticky overflow flag.
- One instance sits per MVU output lane. The upstream lane controller sequences the bit planes and drives sh, neg and last.

Parameters:
- N, 64, vector length of the feeding product tree.
- SW, $clog2(N)+2, input partial-sum width; matches the product tree output width.
- OW, 32, accumulator and output width; must satisfy OW > SW.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_vld  in  1  S and the beat controls are valid
- in_rdy  out  1  beat is accepted when in_vld & in_rdy
- S  in  SW  signed partial sum from the product tree
- sh  in  1  shift the accumulator left by 1 before adding; ignored on the first beat of a result
- neg  in  1  subtract S instead of adding it (sign-bit plane)
- last  in  1  final beat of the current result
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accepts the result when out_vld & out_rdy
- out  out  OW  signed accumulated result
- out_ovf  out  1  overflow occurred while forming this result

Behaviour:
- All clock and reset ports: one clock; reset is synchronous and active-high.
- Reset: out_vld=0, out=0, out_ovf=0; accumulator=0, state=IDLE, sticky ovf=0. A reset mid-accumulation discards the partial sum; a held result is dropped.
- in_rdy = !out_vld | out_rdy. It is combinational and independent of in_vld.
- S is sign-extended to OW+1 before negation, so negating the most negative S never overflows.
- State IDLE (no partial sum):
  - Accepted beat computes base = 0, ignoring sh.
  - nxt = base + (neg ? -S : S).
  - last=0 → ACC. last=1 → result path, stay IDLE.
- State ACC (partial sum held):
  - base = sh ? acc<<1 : acc.
  - nxt = base ± S, as in IDLE.
  - last=1 → result path, → IDLE. last=0 → stay ACC.
- Result path: out <= nxt[OW-1:0], out_ovf <= sticky | ovf_this_beat, out_vld <= 1. The accumulator and sticky flag clear the same cycle.
- Latency: out_vld rises in the cycle after the last beat is accepted.
- out_vld falls after out_vld & out_rdy, unless a new last beat is accepted in the same cycle; in that case out and out_ovf reload and out_vld stays 1.
- out and out_ovf are stable while out_vld & !out_rdy.
- No beat accepted (in_vld=0 or in_rdy=0): accumulator, state and sticky flag hold.
- Overflow detection:
  - The shift overflows when acc[OW-1] != acc[OW-2].
  - The add overflows when the full-precision sum falls outside the signed OW range.
  - Either event sets the sticky flag.
  - The stored value wraps (two's complement truncation).
- Backpressure never corrupts the partial sum. Non-last beats are accepted only when in_rdy=1, which is held low while a result waits.

Test Plan:
- Single beat S=5, neg=0, last=1 → one cycle later out_vld=1, out=5, out_ovf=0. out_rdy=1 → out_vld=0 next cycle.
- Horner sequence:
  - Beats (S,sh,neg,last) = (3,1,0,0), (-2,1,0,0), (1,1,0,1).
  - First-beat sh is ignored. Accumulator steps 3 → 4 → 9.
  - Response: out=9.
- Sign plane: beats (4,0,1,0), (3,1,0,1) → -4 → -5. out=-5, out_ovf=0. A separate case with S=-128 (SW=8), neg=1, last=1 gives out=128.
- Backpressure:
  - Result 7 completes with out_rdy=0 → in_rdy=0, out holds 7 for 5 cycles, and a pending in_vld beat is not consumed.
  - out_rdy=1 → the pending beat is accepted the same cycle.
  - Back-to-back last beats with out_rdy=1 yield one result per cycle.
- Overflow (OW=10): beats S=100, then 3 beats (S=0, sh=1), last on the 3rd. 800 exceeds 511 → out_ovf=1, out=800-1024=-224. The next result S=1, last=1 → out=1, out_ovf=0.
- Reset mid-op: accept (50,0,0,0), assert rst one cycle, then (2,0,0,1) → out=2. Verify out_vld=0 and out=0 during and after reset.
